// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and the APB address decode helper.
package intr_ctrl_pkg;

    localparam logic [4:0] OFF_IPR = 5'h00;
    localparam logic [4:0] OFF_IER = 5'h04;
    localparam logic [4:0] OFF_ITR = 5'h08;
    localparam logic [4:0] OFF_ICR = 5'h0C;
    localparam logic [4:0] OFF_IVR = 5'h10;
    localparam logic [4:0] OFF_EOI = 5'h14;

    localparam int IVR_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Flags unmapped offsets and writes to the read-only registers.
    function automatic logic addr_err(input logic [4:0] off, input logic wr);
        logic err;
        case (off)
            OFF_IPR, OFF_IVR:          err = wr;
            OFF_IER, OFF_ITR,
            OFF_ICR, OFF_EOI:          err = 1'b0;
            default:                   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index asserted request.
module intr_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    // Scan from the top so the lowest asserted index is the last one kept.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            id    = req[i] ? ID_W'(i) : id;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// APB-programmable interrupt controller with edge/level sources, fixed
// priority and a request/acknowledge/end-of-interrupt handshake.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               irq_ack_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    logic [NUM_SRC-1:0] ier_r, itr_r, epend_r, src_r;
    logic [NUM_SRC-1:0] ipr_s, rise_s, clr_s, ack_mask_s, epend_nxt_s, wdata_s;
    logic [4:0]         off_s;
    logic               err_s, wr_s, icr_wr_s, eoi_wr_s, ack_s;
    logic [ID_W-1:0]    cand_id_s, id_nxt_s;
    logic               cand_valid_s, irq_nxt_s;
    logic [31:0]        rd_s;
    state_t             state_r, state_s;
    logic               unused_s;

    assign pready   = 1'b1;
    assign off_s    = paddr[4:0];
    assign wdata_s  = pwdata[NUM_SRC-1:0];
    assign unused_s = ^{paddr[31:5], pwdata[31:NUM_SRC]};

    assign err_s    = addr_err(off_s, pwrite);
    assign wr_s     = psel & penable & pwrite & ~err_s;
    assign icr_wr_s = wr_s & (off_s == OFF_ICR);
    assign eoi_wr_s = wr_s & (off_s == OFF_EOI);
    assign ack_s    = irq_ack_i & (state_r == REQ);

    // Level sources mirror the registered input; edge sources use the latch.
    assign ipr_s       = (epend_r & itr_r) | (src_r & ~itr_r);
    assign rise_s      = irq_src_i & ~src_r;
    assign ack_mask_s  = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id_o;
    assign clr_s       = (icr_wr_s ? wdata_s : '0) | (ack_s ? ack_mask_s : '0);
    assign epend_nxt_s = ((epend_r & ~clr_s) | rise_s) & itr_r;

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (ipr_s & ier_r),
        .id    (cand_id_s),
        .valid (cand_valid_s)
    );

    // Source history, edge-pending latch and configuration registers.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            src_r   <= '0;
            epend_r <= '0;
            ier_r   <= '0;
            itr_r   <= '0;
        end else begin
            src_r   <= irq_src_i;
            epend_r <= epend_nxt_s;
            if (wr_s && (off_s == OFF_IER)) begin
                ier_r <= wdata_s;
            end
            if (wr_s && (off_s == OFF_ITR)) begin
                itr_r <= wdata_s;
            end
        end
    end

    // Request/service handshake next-state and output decode.
    always_comb begin
        state_s   = state_r;
        irq_nxt_s = 1'b0;
        id_nxt_s  = irq_id_o;
        case (state_r)
            IDLE: begin
                if (cand_valid_s) begin
                    state_s   = REQ;
                    irq_nxt_s = 1'b1;
                    id_nxt_s  = cand_id_s;
                end else begin
                    state_s   = IDLE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_s   = SERVICE;
                end else if (cand_valid_s) begin
                    irq_nxt_s = 1'b1;
                    id_nxt_s  = cand_id_s;
                end else begin
                    state_s   = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_wr_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVICE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and registered interrupt outputs.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_r  <= IDLE;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            state_r  <= state_s;
            irq_o    <= irq_nxt_s;
            irq_id_o <= id_nxt_s;
        end
    end

    // Read data mux; write-only registers and unmapped offsets return 0.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (off_s)
            OFF_IPR: rd_s = 32'(ipr_s);
            OFF_IER: rd_s = 32'(ier_r);
            OFF_ITR: rd_s = 32'(itr_r);
            OFF_IVR: begin
                if (state_r != IDLE) begin
                    rd_s = 32'(irq_id_o) | (32'h0000_0001 << IVR_VALID_BIT);
                end else begin
                    rd_s = 32'h0000_0000;
                end
            end
            default: rd_s = 32'h0000_0000;
        endcase
    end

    // Response is captured in SETUP so it is stable throughout ACCESS.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            prdata  <= 32'h0000_0000;
            pslverr <= 1'b0;
        end else if (psel && !penable) begin
            prdata  <= pwrite ? 32'h0000_0000 : rd_s;
            pslverr <= err_s;
        end else if (psel && penable) begin
            prdata  <= prdata;
            pslverr <= pslverr;
        end else begin
            prdata  <= 32'h0000_0000;
            pslverr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized and directed bench for intr_ctrl against a cycle-level
// behavioural model of the controller's rules.
module tb_intr_ctrl;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  irq_src_i = 8'h00;
    logic        irq_ack_i = 1'b0;
    logic        irq_o;
    logic [2:0]  irq_id_o;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: phase 0 idle, 1 requesting, 2 in service.
    bit [7:0]  m_ier, m_itr, m_epend, m_prev;
    int        m_phase, m_id;
    bit        m_irq, m_pslverr;
    bit [31:0] m_prdata;

    intr_ctrl #(.NUM_SRC(8), .ID_W(3)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .irq_src_i (irq_src_i),
        .irq_ack_i (irq_ack_i),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_err(input bit [4:0] off, input bit wr);
        bit mapped;
        mapped = (off == 5'h00) || (off == 5'h04) || (off == 5'h08) ||
                 (off == 5'h0C) || (off == 5'h10) || (off == 5'h14);
        return !mapped || (wr && ((off == 5'h00) || (off == 5'h10)));
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit [7:0]  ipr, act, clr, wd, rise, nep;
        bit [4:0]  off;
        bit        err, wr;
        int        cand;
        if (!preset_n) begin
            m_ier = 8'h00; m_itr = 8'h00; m_epend = 8'h00; m_prev = 8'h00;
            m_phase = 0; m_id = 0; m_irq = 1'b0; m_prdata = 32'h0; m_pslverr = 1'b0;
            return;
        end
        ipr  = (m_epend & m_itr) | (m_prev & ~m_itr);
        act  = ipr & m_ier;
        cand = -1;
        for (int i = 0; i < 8; i++) begin
            if (act[i] && cand < 0) cand = i;
        end
        off = paddr[4:0];
        err = is_err(off, pwrite);
        wr  = psel && penable && pwrite && !err;
        wd  = pwdata[7:0];
        if (psel && !penable) begin
            m_pslverr = err;
            if (pwrite) m_prdata = 32'h0;
            else if (off == 5'h00) m_prdata = {24'h0, ipr};
            else if (off == 5'h04) m_prdata = {24'h0, m_ier};
            else if (off == 5'h08) m_prdata = {24'h0, m_itr};
            else if (off == 5'h10) m_prdata = (m_phase != 0) ? (32'h80 | 32'(m_id)) : 32'h0;
            else m_prdata = 32'h0;
        end else if (!(psel && penable)) begin
            m_pslverr = 1'b0;
            m_prdata  = 32'h0;
        end
        clr = (wr && off == 5'h0C) ? wd : 8'h00;
        if (m_phase == 1 && irq_ack_i) clr[m_id] = 1'b1;
        rise = irq_src_i & ~m_prev;
        nep  = ((m_epend & ~clr) | rise) & m_itr;
        case (m_phase)
            0: begin
                if (cand >= 0) begin m_phase = 1; m_irq = 1'b1; m_id = cand; end
                else m_irq = 1'b0;
            end
            1: begin
                if (irq_ack_i) begin m_phase = 2; m_irq = 1'b0; end
                else if (cand >= 0) begin m_irq = 1'b1; m_id = cand; end
                else begin m_phase = 0; m_irq = 1'b0; end
            end
            default: begin
                m_irq = 1'b0;
                if (wr && off == 5'h14) m_phase = 0;
            end
        endcase
        if (wr && off == 5'h04) m_ier = wd;
        if (wr && off == 5'h08) m_itr = wd;
        m_prev  = irq_src_i;
        m_epend = nep;
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
        check_val("irq_o",   {31'h0, irq_o},   {31'h0, m_irq});
        check_val("irq_id",  32'(irq_id_o),    32'(m_id));
        check_val("prdata",  prdata,           m_prdata);
        check_val("pslverr", {31'h0, pslverr}, {31'h0, m_pslverr});
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        tick();
        penable = 1'b1;
        tick();
        data = prdata;
        err  = pslverr;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [4:0]  offs [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

    initial begin
        // Reset held for two cycles, then every register reads back zero.
        preset_n = 1'b0;
        tick(); tick();
        preset_n = 1'b1;
        check_val("pready", {31'h0, pready}, 32'h1);
        apb_read(32'h00, rd, er); check_val("rst_ipr", rd, 32'h0);
        apb_read(32'h04, rd, er); check_val("rst_ier", rd, 32'h0);
        apb_read(32'h08, rd, er); check_val("rst_itr", rd, 32'h0);
        apb_read(32'h10, rd, er); check_val("rst_ivr", rd, 32'h0);
        check_val("rst_irq", {31'h0, irq_o}, 32'h0);

        // Edge source on bit 1: request, acknowledge auto-clears, EOI returns idle.
        apb_write(32'h04, 32'h02);
        apb_write(32'h08, 32'h02);
        irq_src_i = 8'h02; tick(); irq_src_i = 8'h00;
        apb_read(32'h00, rd, er); check_val("edge_ipr", rd, 32'h02);
        check_val("edge_irq", {31'h0, irq_o}, 32'h1);
        apb_read(32'h10, rd, er); check_val("edge_ivr", rd, 32'h81);
        do_ack();
        check_val("ack_irq", {31'h0, irq_o}, 32'h0);
        apb_read(32'h00, rd, er); check_val("ack_ipr", rd, 32'h0);
        apb_read(32'h10, rd, er); check_val("svc_ivr", rd, 32'h81);
        apb_write(32'h14, 32'h0);
        apb_read(32'h10, rd, er); check_val("eoi_ivr", rd, 32'h0);

        // Level priority: bits 5 and 1 together, then bit 1 drops.
        apb_write(32'h04, 32'hFF);
        apb_write(32'h08, 32'h00);
        irq_src_i = 8'h22; tick(); tick();
        check_val("prio_id1", 32'(irq_id_o), 32'h1);
        do_ack();
        irq_src_i = 8'h20; tick();
        apb_write(32'h14, 32'h0);
        tick();
        check_val("prio_id5", 32'(irq_id_o), 32'h5);
        check_val("prio_irq5", {31'h0, irq_o}, 32'h1);
        do_ack(); apb_write(32'h14, 32'h0);
        irq_src_i = 8'h00; tick(); tick();

        // Preemption before ack: bit 3 requesting, bit 0 arrives.
        irq_src_i = 8'h08; tick(); tick();
        check_val("pre_id3", 32'(irq_id_o), 32'h3);
        irq_src_i = 8'h09; tick(); tick();
        check_val("pre_id0", 32'(irq_id_o), 32'h0);
        check_val("pre_irq", {31'h0, irq_o}, 32'h1);
        irq_src_i = 8'h00; tick(); tick();
        check_val("vanish_irq", {31'h0, irq_o}, 32'h0);

        // Error responses.
        apb_read(32'h18, rd, er);
        check_val("err_rd_slv", {31'h0, er}, 32'h1);
        check_val("err_rd_data", rd, 32'h0);
        apb_write(32'h00, 32'hFF);
        check_val("err_wr_slv", {31'h0, pslverr}, 32'h1);
        apb_read(32'h00, rd, er); check_val("err_ipr", rd, 32'h0);

        // Set/clear collision on an edge bit: the new edge wins.
        apb_write(32'h04, 32'h00);
        apb_write(32'h08, 32'h02);
        irq_src_i = 8'h02; tick(); irq_src_i = 8'h00; tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h02;
        tick();
        penable = 1'b1; irq_src_i = 8'h02;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; irq_src_i = 8'h00;
        apb_read(32'h00, rd, er); check_val("collide_ipr", rd, 32'h02);
        apb_write(32'h0C, 32'h02);
        apb_read(32'h00, rd, er); check_val("icr_ipr", rd, 32'h0);

        // Reset in the middle of a request drops it and forgets the edge.
        apb_write(32'h04, 32'h02);
        irq_src_i = 8'h02; tick(); tick(); irq_src_i = 8'h00;
        check_val("mid_irq", {31'h0, irq_o}, 32'h1);
        preset_n = 1'b0; tick(); preset_n = 1'b1;
        check_val("rst_mid_irq", {31'h0, irq_o}, 32'h0);
        apb_read(32'h00, rd, er); check_val("rst_mid_ipr", rd, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                irq_src_i = 8'($urandom) & 8'($urandom);
                irq_ack_i = ($urandom_range(0, 2) == 0);
                tick();
                irq_ack_i = 1'b0;
            end else if (op < 7) begin
                apb_write({27'($urandom), offs[$urandom_range(0, 7)]}, $urandom);
            end else if (op < 9) begin
                apb_read({27'($urandom), offs[$urandom_range(0, 7)]}, rd, er);
            end else begin
                preset_n = ($urandom_range(0, 7) != 0);
                tick();
                preset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources; legal range 2..8.
REQ-002 Parameter ID_W, default 3, width of source id, $clog2(NUM_SRC).
REQ-003 pclk  input  1  sole clock; all state updates on rising edge.
REQ-004 preset_n  input  1  synchronous active-low reset, sampled on rising pclk.
REQ-005 psel, penable, pwrite  input  1 each  APB control.
REQ-006 paddr  input  32  APB address; bits [4:0] decoded, upper bits ignored.
REQ-007 pwdata  input  32  APB write data.
REQ-008 prdata  output  32  APB read data, valid in ACCESS phase.
REQ-009 pready  output  1  tied 1, zero wait states.
REQ-010 pslverr  output  1  error flag, valid in ACCESS phase.
REQ-011 irq_src_i  input  NUM_SRC  interrupt requests, pclk-synchronous; bit 1 = timer underflow, bit 0 = timer overflow.
REQ-012 irq_ack_i  input  1  single-cycle CPU acknowledge pulse.
REQ-013 irq_o  output  1  interrupt request to CPU.
REQ-014 irq_id_o  output  ID_W  id of the source being requested or serviced.

Function
REQ-015 Register map: 0x00 IPR pending (RO); 0x04 IER enable (RW); 0x08 ITR trigger, 1=rising edge, 0=level (RW); 0x0C ICR clear (WO, W1C on edge pending, reads 0); 0x10 IVR (RO: bit7 valid, [ID_W-1:0] id); 0x14 EOI (WO, any data, reads 0).
REQ-016 Register write commits on the cycle with psel & penable & pwrite; only bits [NUM_SRC-1:0] are stored, others read 0.
REQ-017 pslverr=1 in ACCESS for an unmapped offset or a write to IPR/IVR; no state changes on an errored access.
REQ-018 Edge source: pending sets the cycle after irq_src_i goes 0->1, using a registered copy of irq_src_i; stays set until ICR write of 1 on that bit.
REQ-019 Simultaneous new edge and ICR clear on the same bit: set wins.
REQ-020 Level source: pending bit equals registered irq_src_i; ICR writes to it are ignored.
REQ-021 Candidate = lowest-index bit of (IPR & IER); fixed priority, bit 0 highest.
REQ-022 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-023 IDLE -> REQ when a candidate exists; irq_id_o latches candidate id, irq_o=1 registered (one-cycle latency from pending to irq_o).
REQ-024 REQ: irq_o held 1; irq_id_o updated to a higher-priority candidate if one appears before ack; if candidate vanishes (disabled/cleared) before ack, return to IDLE with irq_o=0.
REQ-025 REQ -> SERVICE on irq_ack_i=1; irq_o=0 next cycle; irq_id_o frozen; an edge source's pending bit is cleared automatically at ack.
REQ-026 SERVICE -> IDLE on EOI write; no nesting, new requests wait in IPR.
REQ-027 irq_ack_i in IDLE or SERVICE is ignored.
REQ-028 IVR reads {1,id} in REQ and SERVICE, 0 in IDLE.

Reset
REQ-029 On preset_n=0 at a rising edge: IPR, IER, ITR, edge-history register, irq_o, irq_id_o cleared to 0; FSM to IDLE; prdata=0, pslverr=0.
REQ-030 Reset mid-REQ or mid-SERVICE aborts the interrupt without requiring EOI; no pending edge is retained.

Structure
REQ-031 Shared package intr_ctrl_pkg holds register offsets, the FSM state enum (IDLE, REQ, SERVICE) and IVR valid-bit position.
REQ-032 One sub-module, intr_prio_enc: combinational lowest-index priority encoder, outputs id and valid.

Verification
REQ-033 Reset: hold preset_n=0 2 cycles -> all registers read 0, irq_o=0, IVR=0x00.
REQ-034 Edge on bit 1: IER=0x02, ITR=0x02, pulse irq_src_i[1] -> IPR=0x02, irq_o=1 one cycle later, IVR=0x81; ack -> irq_o=0, IPR=0x00; EOI -> IDLE.
REQ-035 Priority: IER=0xFF, raise bits 5 and 1 level same cycle -> irq_id_o=1; after ack+EOI with bit 1 dropped -> irq_id_o=5.
REQ-036 Preemption before ack: bit 3 pending in REQ, then bit 0 rises -> irq_id_o changes 3->0 with irq_o staying 1.
REQ-037 Errors: read 0x18 -> pslverr=1, prdata=0; write 0x00 -> pslverr=1, IPR unchanged.
REQ-038 Set/clear collision: ICR write 0x02 on the same cycle bit 1 edge arrives -> IPR bit 1 remains 1.
